updown_counter_p: RTL and testbench
===================================

Name: updown_counter_p

Overview:
- Parametrised successor to the 8-bit up/down counter.
- Adds:
  - generic width;
  - runtime-programmable terminal value;
  - wrap or saturate mode;
  - enable prescaler;
  - synchronous load;
  - registered carry/borrow pulses and status flags.
- Used as a general event/position counter and as a programmable-modulus timebase.

Parameters:
- WIDTH, 8: counter and limit width in bits (≥2).
- PRESCALE, 1: enabled clocks per count step (≥1). 1 means a step on every enabled clock.
- MODE, 0: 0 = wrap (modulo lim+1), 1 = saturate at 0 / lim.

Ports:
- clk: input, 1. Rising-edge clock.
- rst: input, 1. Asynchronous reset, active-low (asserted at 0).
- en: input, 1. Count enable; gates the prescaler.
- up: input, 1. Count-up request.
- down: input, 1. Count-down request.
- load: input, 1. Synchronous load strobe.
- load_val: input, WIDTH. Value to load.
- lim: input, WIDTH. Terminal value; the count range is 0..lim.
- count: output, WIDTH. Registered count value.
- c_out: output, 1. Registered one-cycle carry pulse on an overflow tick.
- b_out: output, 1. Registered one-cycle borrow pulse on an underflow tick.
- at_lim: output, 1. Combinational: count == lim.
- at_zero: output, 1. Combinational: count == 0.

Behaviour:

Reset
- rst = 0 (asynchronous, takes effect immediately): count = 0, c_out = 0, b_out = 0, prescaler = 0.
- Leaving reset is synchronous to clk; the first update is on the first rising edge with rst = 1.
- Reset mid-count or mid-prescale discards all state. No pulse is generated.

Prescaler
- Internal counter psc, 0..PRESCALE-1, advances only when en = 1 and load = 0. It wraps to 0.
- tick = en & (psc == PRESCALE-1). With PRESCALE = 1, tick = en.
- en = 0: psc and count hold; no pulses.

Priority per rising edge: load > tick > hold.
- load = 1:
  - count <= min(load_val, lim);
  - psc <= 0;
  - c_out = b_out = 0;
  - up/down/en are ignored that cycle.
- tick = 1, direction decoded:
  - up & ~down: increment;
  - down & ~up: decrement;
  - both or neither: hold.
  - psc still advances on a hold, and no pulse is generated.
- Increment:
  - count < lim: count + 1.
  - count >= lim (overflow): c_out = 1 for exactly one cycle.
    - MODE 0: count <= 0.
    - MODE 1: count <= lim.
- Decrement:
  - count > 0: count - 1, including the case count > lim after lim was lowered.
  - count == 0 (underflow): b_out = 1 for exactly one cycle.
    - MODE 0: count <= lim.
    - MODE 1: count stays 0.
- c_out/b_out timing:
  - registered;
  - asserted in the same cycle count shows its post-event value;
  - deasserted the next cycle unless another overflow/underflow tick occurs there.
  - In MODE 1, repeated ticks against a limit produce a pulse on each tick.

Runtime limit
- lim is sampled every cycle; there is no shadow register.
- Lowering lim below count leaves count unchanged until the next up tick, which is treated as overflow.
- lim = 0:
  - count is confined to 0 (after load or reset);
  - every up tick pulses c_out;
  - every down tick pulses b_out.

Arithmetic
- Unsigned, WIDTH bits. No intermediate overflow.
- lim = 2^WIDTH-1 behaves as a full-range binary counter.
- Latency: one clock from a tick or load to the count change.
- at_lim/at_zero follow count and lim combinationally.

Test Plan:
1. Reset and load
   - Setup: WIDTH = 8, MODE 0, PRESCALE = 1, lim = 255. Hold rst = 0 while en/up = 1, then release. Load load_val = 10.
   - Required:
     - count = 0 and c_out = 0 throughout reset;
     - count = 10 one clock after load;
     - an asserted load beats a simultaneous up tick.
2. Wrap
   - Setup: lim = 5, count = 4, up = 1, en = 1.
   - Required:
     - sequence 5, 0, 1;
     - c_out = 1 only in the cycle count = 0;
     - at_lim = 1 while count = 5.
   - Then down from 0: count = 5, b_out pulses once.
3. Saturate
   - Setup: MODE 1, lim = 200, count = 199, up held for 3 ticks.
   - Required: count 200, 200, 200; c_out = 1 on the 2nd and 3rd ticks.
   - Then down from 0 for 2 ticks: count = 0 and b_out = 1 both ticks.
4. Prescaler and direction conflict
   - Setup: PRESCALE = 4, up = 1, en = 1 for 12 clocks.
   - Required: count increments by 1 every 4th clock, reaching 3.
   - up = down = 1: count holds and no pulses, psc still cycles.
   - en = 0 mid-period: psc freezes and resumes from the same phase.
5. Runtime limit and async reset
   - Setup: count = 50, lim lowered to 20.
   - Required:
     - next down tick gives 49;
     - next up tick overflows: MODE 0 gives count = 0, c_out = 1.
   - Assert rst mid-prescale (psc = 2): outputs clear without waiting for clk.
   - Load load_val = 30 with lim = 20: count = 20.

Source files
------------

// File: rtl/updown_counter_p.sv
// rtl/updown_counter_p.sv - parametrised up/down counter with prescaler, load, wrap/saturate and carry/borrow pulses
module updown_counter_p #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int MODE     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] lim,
  output logic [WIDTH-1:0] count,
  output logic             c_out,
  output logic             b_out,
  output logic             at_lim,
  output logic             at_zero
);

  // A single-bit prescaler is kept even for PRESCALE = 1; it then never leaves 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    psc_q, psc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             c_q, c_d;
  logic             b_q, b_d;
  logic             tick;

  // Next-state: load beats tick beats hold; pulses default low so they last one cycle.
  always_comb begin
    tick    = en & (psc_q == PSC_LAST);
    psc_d   = psc_q;
    count_d = count_q;
    c_d     = 1'b0;
    b_d     = 1'b0;
    if (load) begin
      count_d = (load_val > lim) ? lim : load_val;
      psc_d   = '0;
    end else begin
      if (en) begin
        psc_d = (psc_q == PSC_LAST) ? '0 : psc_q + PW'(1);
      end
      if (tick && up && !down) begin
        // count may exceed lim after lim was lowered; that also counts as overflow
        if (count_q < lim) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          c_d     = 1'b1;
          count_d = (MODE == 1) ? lim : '0;
        end
      end else if (tick && down && !up) begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          b_d     = 1'b1;
          count_d = (MODE == 1) ? '0 : lim;
        end
      end
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc_q   <= '0;
      count_q <= '0;
      c_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      psc_q   <= psc_d;
      count_q <= count_d;
      c_q     <= c_d;
      b_q     <= b_d;
    end
  end

  assign count   = count_q;
  assign c_out   = c_q;
  assign b_out   = b_q;
  assign at_lim  = (count_q == lim);
  assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_p.sv
// tb/tb_updown_counter_p.sv - scoreboard bench for updown_counter_p in wrap, saturate and prescaled variants
module tb_updown_counter_p;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, down, load;
  logic [7:0] load_val, lim;

  logic [7:0] cnt0, cnt1, cnt4;
  logic       c0, b0, al0, az0;
  logic       c1, b1, al1, az1;
  logic       c4, b4, al4, az4;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int         k;
    logic [11:0] v;
  } sb_t;
  sb_t sbq[$];

  logic [11:0] obs[3];
  int mc[3];
  int mp[3];
  int pp[3] = '{1, 1, 4};
  int mm[3] = '{0, 1, 0};

  always #5 clk = ~clk;

  updown_counter_p #(.WIDTH(8), .PRESCALE(1), .MODE(0)) d0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load),
    .load_val(load_val), .lim(lim), .count(cnt0), .c_out(c0), .b_out(b0),
    .at_lim(al0), .at_zero(az0));
  updown_counter_p #(.WIDTH(8), .PRESCALE(1), .MODE(1)) d1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load),
    .load_val(load_val), .lim(lim), .count(cnt1), .c_out(c1), .b_out(b1),
    .at_lim(al1), .at_zero(az1));
  updown_counter_p #(.WIDTH(8), .PRESCALE(4), .MODE(0)) d4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load),
    .load_val(load_val), .lim(lim), .count(cnt4), .c_out(c4), .b_out(b4),
    .at_lim(al4), .at_zero(az4));

  assign obs[0] = {cnt0, c0, b0, al0, az0};
  assign obs[1] = {cnt1, c1, b1, al1, az1};
  assign obs[2] = {cnt4, c4, b4, al4, az4};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one counter instance for the inputs currently driven.
  task automatic model_push(input int k);
    int c, ps, L;
    bit co, bo, t;
    sb_t e;
    c  = mc[k];
    ps = mp[k];
    L  = int'(lim);
    co = 0;
    bo = 0;
    if (load) begin
      c  = (int'(load_val) < L) ? int'(load_val) : L;
      ps = 0;
    end else if (en) begin
      t  = (ps == pp[k] - 1);
      ps = t ? 0 : ps + 1;
      if (t && up && !down) begin
        if (c >= L) begin co = 1; c = (mm[k] == 1) ? L : 0; end
        else c = c + 1;
      end else if (t && down && !up) begin
        if (c == 0) begin bo = 1; c = (mm[k] == 1) ? 0 : L; end
        else c = c - 1;
      end
    end
    mc[k] = c;
    mp[k] = ps;
    e.k = k;
    e.v = {8'(c), co, bo, (c == L), (c == 0)};
    sbq.push_back(e);
  endtask

  task automatic step();
    sb_t e;
    for (int k = 0; k < 3; k++) model_push(k);
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check_eq($sformatf("sb%0d", e.k), 32'(obs[e.k]), 32'(e.v));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin mc[k] = 0; mp[k] = 0; end
  endtask

  task automatic do_load(input logic [7:0] v);
    load_val = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; up = 1'b1; down = 1'b0; load = 1'b0;
    load_val = 8'd0; lim = 8'd255;
    model_reset();
    #1;
    check_eq("rst_cnt", 32'(cnt0), 32'd0);
    check_eq("rst_c", 32'(c0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_hold_cnt", 32'(cnt0), 32'd0);
      check_eq("rst_hold_c", 32'(c0), 32'd0);
    end
    rst = 1'b1;

    // load beats a simultaneous up tick
    do_load(8'd10);
    check_eq("load10", 32'(cnt0), 32'd10);
    step();
    check_eq("up11", 32'(cnt0), 32'd11);

    // wrap at lim = 5
    lim = 8'd5;
    do_load(8'd4);
    step();
    check_eq("wrap5", 32'(cnt0), 32'd5);
    check_eq("wrap5_atlim", 32'(al0), 32'd1);
    check_eq("wrap5_c", 32'(c0), 32'd0);
    step();
    check_eq("wrap0", 32'(cnt0), 32'd0);
    check_eq("wrap0_c", 32'(c0), 32'd1);
    step();
    check_eq("wrap1", 32'(cnt0), 32'd1);
    check_eq("wrap1_c", 32'(c0), 32'd0);
    do_load(8'd0);
    up = 1'b0; down = 1'b1;
    step();
    check_eq("under_lim", 32'(cnt0), 32'd5);
    check_eq("under_b", 32'(b0), 32'd1);
    step();
    check_eq("under_next_b", 32'(b0), 32'd0);

    // saturate at lim = 200 and at 0
    lim = 8'd200;
    up = 1'b1; down = 1'b0;
    do_load(8'd199);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("sat_cnt", 32'(cnt1), 32'd200);
      check_eq("sat_c", 32'(c1), (i == 0) ? 32'd0 : 32'd1);
    end
    do_load(8'd0);
    up = 1'b0; down = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("sat0_cnt", 32'(cnt1), 32'd0);
      check_eq("sat0_b", 32'(b1), 32'd1);
    end

    // prescaler of 4
    lim = 8'd255;
    up = 1'b1; down = 1'b0;
    do_load(8'd0);
    for (int i = 1; i <= 12; i++) begin
      step();
      check_eq("psc_cnt", 32'(cnt4), 32'(i / 4));
    end
    down = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("conflict_cnt", 32'(cnt4), 32'd3);
      check_eq("conflict_c", 32'(c0), 32'd0);
    end
    down = 1'b0;
    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    en = 1'b1;
    step();
    check_eq("resume_hold", 32'(cnt4), 32'd3);
    step();
    check_eq("resume_tick", 32'(cnt4), 32'd4);

    // runtime limit lowered below count
    do_load(8'd50);
    lim = 8'd20;
    up = 1'b0; down = 1'b1;
    step();
    check_eq("lowlim_dn", 32'(cnt0), 32'd49);
    up = 1'b1; down = 1'b0;
    step();
    check_eq("lowlim_up", 32'(cnt0), 32'd0);
    check_eq("lowlim_c", 32'(c0), 32'd1);

    // asynchronous reset with the prescaler at phase 2
    do_load(8'd7);
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_cnt0", 32'(cnt0), 32'd0);
    check_eq("arst_cnt4", 32'(cnt4), 32'd0);
    check_eq("arst_c0", 32'(c0), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    do_load(8'd30);
    check_eq("load_clip", 32'(cnt0), 32'd20);

    // lim = 0 pulses on every tick
    lim = 8'd0;
    do_load(8'd9);
    step();
    check_eq("lim0_c", 32'(c0), 32'd1);
    up = 1'b0; down = 1'b1;
    step();
    check_eq("lim0_b", 32'(b0), 32'd1);
    check_eq("lim0_cnt", 32'(cnt0), 32'd0);

    // full-range rollover
    lim = 8'd255;
    up = 1'b1; down = 1'b0;
    do_load(8'd254);
    step();
    step();
    check_eq("full_wrap", 32'(cnt0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
